// File: rtl/fifo_wptr_full.sv
// Write-domain pointer and status logic of the dual-clock FIFO: binary/Gray write
// pointers, full, almost_full and level. `FIFO_OVERFLOW_STICKY_EN adds a sticky overflow flag.
module fifo_wptr_full #(
  parameter int ADDR_WIDTH   = 4,
  parameter int AFULL_THRESH = 12
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH:0]   rptr_gray_sync,
  output logic                  wr_accept,
  output logic [ADDR_WIDTH-1:0] waddr,
  output logic [ADDR_WIDTH:0]   wptr_gray,
  output logic                  full,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   wr_level
`ifdef FIFO_OVERFLOW_STICKY_EN
  ,
  output logic                  overflow
`endif
);

  localparam int PTR_W = ADDR_WIDTH + 1;

  logic [PTR_W-1:0] wbin;
  logic [PTR_W-1:0] wbin_next;
  logic [PTR_W-1:0] wgray_next;
  logic [PTR_W-1:0] rbin;
  logic [PTR_W-1:0] level_next;
  logic [PTR_W-1:0] full_pattern;
  logic             full_next;
  logic             afull_next;

  assign wr_accept = wr_en & ~full;
  assign waddr     = wbin[ADDR_WIDTH-1:0];

  assign wbin_next  = wbin + PTR_W'(wr_accept);
  assign wgray_next = (wbin_next >> 1) ^ wbin_next;

  // Full when the write pointer is exactly one lap ahead: in Gray code that is
  // the read pointer with its two MSBs inverted.
  assign full_pattern = {~rptr_gray_sync[PTR_W-1:PTR_W-2], rptr_gray_sync[PTR_W-3:0]};
  assign full_next    = (wgray_next == full_pattern);

  // Gray-to-binary: each binary bit is the XOR of all Gray bits at or above it.
  // NOTE: every bit is assigned on every pass, so no latch can be inferred.
  always_comb begin
    rbin = '0;
    for (int i = 0; i < PTR_W; i++) begin
      rbin[i] = ^(rptr_gray_sync >> i);
    end
  end

  // Level uses the synchronized (stale) read pointer, so it can only overstate occupancy.
  assign level_next = wbin_next - rbin;
  assign afull_next = (level_next >= PTR_W'(AFULL_THRESH));

  // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin        <= '0;
      wptr_gray   <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
    end else begin
      wbin        <= wbin_next;
      wptr_gray   <= wgray_next;
      full        <= full_next;
      almost_full <= afull_next;
      wr_level    <= level_next;
    end
  end

`ifdef FIFO_OVERFLOW_STICKY_EN
  // Sticky until reset: records that at least one write was dropped while full.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
    end else if (wr_en && full) begin
      overflow <= 1'b1;
    end
  end
`endif

endmodule
